// File: rtl/hier_fanout_node.sv
// Interior tree node: broadcasts one command to NUM_CHILD children,
// folds their responses (XOR or sum) and returns one aggregate upstream.
module hier_fanout_node #(
    parameter int NUM_CHILD = 10,
    parameter int DATA_W    = 16,
    parameter int TIMEOUT_W = 8,
    parameter int AGG_MODE  = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        up_cmd_valid,
    output logic                        up_cmd_ready,
    input  logic [DATA_W-1:0]           up_cmd_data,
    input  logic [TIMEOUT_W-1:0]        timeout_cyc,
    output logic                        up_rsp_valid,
    input  logic                        up_rsp_ready,
    output logic [DATA_W-1:0]           up_rsp_data,
    output logic                        up_rsp_err,
    output logic [NUM_CHILD-1:0]        up_rsp_mask,
    output logic [NUM_CHILD-1:0]        dn_cmd_valid,
    input  logic [NUM_CHILD-1:0]        dn_cmd_ready,
    output logic [DATA_W-1:0]           dn_cmd_data,
    input  logic [NUM_CHILD-1:0]        dn_rsp_valid,
    output logic [NUM_CHILD-1:0]        dn_rsp_ready,
    input  logic [NUM_CHILD*DATA_W-1:0] dn_rsp_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic                   rdy_q;
    logic [DATA_W-1:0]      data_q, data_d;
    logic [TIMEOUT_W-1:0]   tmo_q, tmo_d;
    logic [TIMEOUT_W-1:0]   timer_q, timer_d;
    logic [NUM_CHILD-1:0]   issue_q, issue_d;
    logic [NUM_CHILD-1:0]   rsp_q, rsp_d;
    logic [NUM_CHILD-1:0]   err_q, err_d;
    logic [DATA_W-1:0]      acc_q, acc_d;

    logic [NUM_CHILD-1:0]   cmd_hs;
    logic [NUM_CHILD-1:0]   rsp_hs;
    logic [NUM_CHILD-1:0]   pend;
    logic [DATA_W-1:0]      fold;

    assign cmd_hs = issue_q & dn_cmd_ready;
    assign rsp_hs = rsp_q & dn_rsp_valid;

    // Fold every child response handshaking this cycle into the accumulator
    always_comb begin
        fold = acc_q;
        for (int i = 0; i < NUM_CHILD; i++) begin
            if (rsp_hs[i]) begin
                if (AGG_MODE == 0) begin
                    fold = fold ^ dn_rsp_data[i*DATA_W +: DATA_W];
                end else begin
                    fold = fold + dn_rsp_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Next-state logic: command accept, per-child tracking, completion/timeout
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        tmo_d   = tmo_q;
        timer_d = timer_q;
        issue_d = issue_q;
        rsp_d   = rsp_q;
        err_d   = err_q;
        acc_d   = acc_q;
        pend    = '0;
        unique case (state_q)
            IDLE: begin
                if (up_cmd_valid && rdy_q) begin
                    data_d  = up_cmd_data;
                    tmo_d   = timeout_cyc;
                    issue_d = '1;
                    rsp_d   = '0;
                    acc_d   = '0;
                    timer_d = '0;
                    err_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                issue_d = issue_q & ~cmd_hs;
                rsp_d   = (rsp_q & ~rsp_hs) | cmd_hs;
                acc_d   = fold;
                if (timer_q != '1) begin
                    timer_d = timer_q + TIMEOUT_W'(1);
                end
                pend = issue_d | rsp_d;
                if (pend == '0) begin
                    state_d = RESP;
                end else if ((tmo_q != '0) &&
                             (timer_q == tmo_q - TIMEOUT_W'(1))) begin
                    err_d   = pend;
                    issue_d = '0;
                    rsp_d   = '0;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (up_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; ready flag is registered so it stays low through reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rdy_q   <= 1'b0;
            data_q  <= '0;
            tmo_q   <= '0;
            timer_q <= '0;
            issue_q <= '0;
            rsp_q   <= '0;
            err_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= (state_d == IDLE);
            data_q  <= data_d;
            tmo_q   <= tmo_d;
            timer_q <= timer_d;
            issue_q <= issue_d;
            rsp_q   <= rsp_d;
            err_q   <= err_d;
            acc_q   <= acc_d;
        end
    end

    assign up_cmd_ready = rdy_q;
    assign up_rsp_valid = (state_q == RESP);
    assign up_rsp_data  = acc_q;
    assign up_rsp_err   = |err_q;
    assign up_rsp_mask  = err_q;
    assign dn_cmd_valid = issue_q;
    assign dn_cmd_data  = data_q;
    assign dn_rsp_ready = rsp_q;

endmodule
